// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding,
// register-index width and default counter parameters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MISS = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int REG_W       = 5;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a load in EX writing a register that the
// instruction in ID reads. Register 0 never creates a dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  output logic             hazard
);

  assign hazard = idex_memread_i && (idex_rt_i != '0) &&
                  ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freeze on dcache miss,
// bubble on load-use, flush on redirect, plus statistics and a miss watchdog.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_stall_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             branch_i,
  input  logic             jump_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_bubble_o,
  output logic             exmem_stall_o,
  output logic             memwb_stall_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [1:0]       state_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  state_t           r_state;
  logic [CNT_W-1:0] r_miss_cnt, r_bubble_cnt, r_consec;
  logic             r_err;
  logic             w_hazard;
  logic [CNT_W-1:0] w_consec_nxt;

  load_use_detect u_lud (
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .hazard         (w_hazard)
  );

  // Priority: reset, freeze, load-use, redirect. A branch during load-use is
  // not flushed because its operand is still being loaded.
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_stall_o  = 1'b0;
    idex_bubble_o = 1'b0;
    exmem_stall_o = 1'b0;
    memwb_stall_o = 1'b0;
    if (rst_i) begin
      pc_write_o = 1'b0;
    end else if (mem_stall_i) begin
      ifid_stall_o  = 1'b1;
      idex_stall_o  = 1'b1;
      exmem_stall_o = 1'b1;
      memwb_stall_o = 1'b1;
    end else if (w_hazard) begin
      ifid_stall_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (branch_i || jump_i) begin
      pc_write_o   = 1'b1;
      ifid_flush_o = 1'b1;
    end else begin
      pc_write_o = 1'b1;
    end
  end

  assign w_consec_nxt = !mem_stall_i          ? '0 :
                        (r_consec >= TO_VAL)  ? TO_VAL :
                                                r_consec + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_RUN;
      r_miss_cnt   <= '0;
      r_bubble_cnt <= '0;
      r_consec     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_consec <= w_consec_nxt;
      if (mem_stall_i && r_miss_cnt != CNT_MAX)
        r_miss_cnt <= r_miss_cnt + 1'b1;
      if (idex_bubble_o && r_bubble_cnt != CNT_MAX)
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      case (r_state)
        ST_RUN:  if (mem_stall_i) r_state <= ST_MISS;
        ST_MISS: begin
          if (!mem_stall_i) begin
            r_state <= ST_RUN;
          end else if (w_consec_nxt == TO_VAL) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end
        end
        ST_ERR:  if (!mem_stall_i) r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign miss_cnt_o   = r_miss_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
  assign state_o      = r_state;
  assign err_o        = r_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (CNT_W=4, TIMEOUT=8): vector table
// for single-cycle priority decode, then multi-cycle miss/watchdog sequences.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  // {pc_write, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_stall}
  localparam logic [6:0] C_IDLE   = 7'b1000000;
  localparam logic [6:0] C_FREEZE = 7'b0101011;
  localparam logic [6:0] C_LU     = 7'b0100100;
  localparam logic [6:0] C_REDIR  = 7'b1010000;
  localparam logic [6:0] C_RST    = 7'b0000000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic mem_stall_i = 1'b0, idex_memread_i = 1'b0, branch_i = 1'b0, jump_i = 1'b0;
  logic [4:0] idex_rt_i = '0, ifid_rs_i = '0, ifid_rt_i = '0;
  logic pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_bubble_o;
  logic exmem_stall_o, memwb_stall_o, err_o;
  logic [CNT_W-1:0] miss_cnt_o, bubble_cnt_o;
  logic [1:0] state_o;
  logic [6:0] ctl;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];

  typedef struct {
    logic       st, mr;
    logic [4:0] rt, rs, rtid;
    logic       br, jp;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[12];

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_stall_i(mem_stall_i),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .branch_i(branch_i), .jump_i(jump_i),
    .pc_write_o(pc_write_o), .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
    .idex_stall_o(idex_stall_o), .idex_bubble_o(idex_bubble_o),
    .exmem_stall_o(exmem_stall_o), .memwb_stall_o(memwb_stall_o),
    .miss_cnt_o(miss_cnt_o), .bubble_cnt_o(bubble_cnt_o),
    .state_o(state_o), .err_o(err_o)
  );

  assign ctl = {pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
                idex_bubble_o, exmem_stall_o, memwb_stall_o};

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, expected controls queued, compared after settle.
  task automatic step(input logic st, mr, input logic [4:0] rt, rs, rtid,
                      input logic br, jp, input logic [6:0] exp, input string nm);
    @(negedge clk_i);
    mem_stall_i = st; idex_memread_i = mr; idex_rt_i = rt;
    ifid_rs_i = rs; ifid_rt_i = rtid; branch_i = br; jump_i = jp;
    exp_q.push_back(exp);
    #2;
    chk(nm, 32'(ctl), 32'(exp_q.pop_front()));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    mem_stall_i = 0; idex_memread_i = 0; idex_rt_i = 0;
    ifid_rs_i = 0; ifid_rt_i = 0; branch_i = 0; jump_i = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, C_IDLE};
    vecs[1]  = '{0, 1, 8, 8, 0, 0, 0, C_LU};
    vecs[2]  = '{0, 1, 0, 0, 0, 0, 0, C_IDLE};
    vecs[3]  = '{0, 1, 5, 3, 5, 0, 0, C_LU};
    vecs[4]  = '{0, 0, 8, 8, 8, 0, 0, C_IDLE};
    vecs[5]  = '{0, 1, 8, 9, 10, 0, 0, C_IDLE};
    vecs[6]  = '{0, 0, 0, 0, 0, 1, 0, C_REDIR};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 1, C_REDIR};
    vecs[8]  = '{0, 1, 7, 7, 0, 1, 0, C_LU};
    vecs[9]  = '{1, 0, 0, 0, 0, 0, 0, C_FREEZE};
    vecs[10] = '{1, 1, 7, 7, 0, 1, 1, C_FREEZE};
    vecs[11] = '{0, 1, 31, 0, 31, 0, 0, C_LU};

    // Reset state, held asynchronously
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_state", 32'(state_o), 0);
    chk("rst_miss", 32'(miss_cnt_o), 0);
    chk("rst_bubble", 32'(bubble_cnt_o), 0);
    chk("rst_err", 32'(err_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    step(0, 0, 0, 0, 0, 0, 0, C_IDLE, "idle_ctl");
    chk("idle_state", 32'(state_o), 0);

    // Priority decode table: 4 bubbles, 2 miss cycles
    for (int i = 0; i < 12; i++)
      step(vecs[i].st, vecs[i].mr, vecs[i].rt, vecs[i].rs, vecs[i].rtid,
           vecs[i].br, vecs[i].jp, vecs[i].exp, $sformatf("vec%0d_ctl", i));
    step(0, 0, 0, 0, 0, 0, 0, C_IDLE, "vec_tail_ctl");
    chk("vec_bubble_cnt", 32'(bubble_cnt_o), 4);
    chk("vec_miss_cnt", 32'(miss_cnt_o), 2);
    chk("vec_state", 32'(state_o), 0);

    // Single load-use bubble, then hazard gone
    do_reset();
    step(0, 1, 8, 8, 0, 0, 0, C_LU, "lu_bubble");
    step(0, 0, 8, 8, 0, 0, 0, C_IDLE, "lu_after");
    chk("lu_bubble_cnt", 32'(bubble_cnt_o), 1);

    // 5-cycle miss: state lags freeze by one cycle
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0, 0, 0, 0, C_FREEZE, $sformatf("miss5_ctl%0d", k));
      chk($sformatf("miss5_state%0d", k), 32'(state_o), (k == 0) ? 0 : 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, C_IDLE, "miss5_release");
    chk("miss5_state_rel", 32'(state_o), 1);
    step(0, 0, 0, 0, 0, 0, 0, C_IDLE, "miss5_idle");
    chk("miss5_state_run", 32'(state_o), 0);
    chk("miss5_cnt", 32'(miss_cnt_o), 5);

    // Freeze with branch + load-use pending: bubble first, then flush
    do_reset();
    for (int k = 0; k < 3; k++)
      step(1, 1, 9, 9, 0, 1, 0, C_FREEZE, $sformatf("combo_frz%0d", k));
    chk("combo_bubble_frz", 32'(bubble_cnt_o), 0);
    step(0, 1, 9, 9, 0, 1, 0, C_LU, "combo_bubble");
    step(0, 0, 9, 9, 0, 1, 0, C_REDIR, "combo_flush");
    step(0, 0, 0, 0, 0, 0, 0, C_IDLE, "combo_idle");
    chk("combo_bubble_cnt", 32'(bubble_cnt_o), 1);

    // Watchdog: ERR after 8 consecutive miss edges, sticky err
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 0, 0, 0, 0, C_FREEZE, $sformatf("wd_ctl%0d", k));
      if (k == 0 || k == 7 || k == 8 || k == 9) begin
        chk($sformatf("wd_state%0d", k), 32'(state_o), (k == 0) ? 0 : (k < 8) ? 1 : 2);
        chk($sformatf("wd_err%0d", k), 32'(err_o), (k < 8) ? 0 : 1);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, C_IDLE, "wd_release");
    step(0, 0, 0, 0, 0, 0, 0, C_IDLE, "wd_idle");
    chk("wd_state_run", 32'(state_o), 0);
    chk("wd_err_sticky", 32'(err_o), 1);
    do_reset();
    #2;
    chk("wd_err_cleared", 32'(err_o), 0);

    // Saturation, then asynchronous reset mid-miss
    do_reset();
    for (int k = 0; k < 20; k++)
      step(1, 0, 0, 0, 0, 0, 0, C_FREEZE, $sformatf("sat_ctl%0d", k));
    step(1, 0, 0, 0, 0, 0, 0, C_FREEZE, "sat_ctl20");
    chk("sat_miss_cnt", 32'(miss_cnt_o), 15);
    #1;
    rst_i = 1'b1;
    #1;
    chk("arst_miss_cnt", 32'(miss_cnt_o), 0);
    chk("arst_state", 32'(state_o), 0);
    chk("arst_err", 32'(err_o), 0);
    chk("arst_ctl", 32'(ctl), 32'(C_RST));
    @(negedge clk_i);
    mem_stall_i = 1'b0;
    rst_i = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, C_IDLE, "post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
